// File: rtl/apb_pkg.sv
// apb_pkg: shared APB master state encoding and default bus widths
package apb_pkg;

    localparam int APB_DATA_WIDTH = 16;
    localparam int APB_ADDR_WIDTH = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'b100,
        SETUP  = 3'b010,
        ACCESS = 3'b001
    } apb_master_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin picker; r_ptr is the first index searched
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    localparam int IW = $clog2(NUM_REQ)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [NUM_REQ-1:0] i_req,
    input  logic               i_update,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IW-1:0]      o_idx
);

    logic [IW-1:0] r_ptr;
    int            w_j;

    // walk from the farthest slot back to r_ptr so the nearest requester wins
    always_comb begin
        o_idx = '0;
        w_j = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_j = int'(r_ptr) + k;
            if (w_j >= NUM_REQ) w_j = w_j - NUM_REQ;
            if (i_req[w_j]) o_idx = IW'(w_j);
        end
    end

    assign o_grant = {{(NUM_REQ-1){1'b0}}, |i_req} << o_idx;

    // search restarts just past the winner, only when a grant is taken
    always_ff @(posedge i_clk) begin
        if (i_rst) r_ptr <= '0;
        else if (i_update) r_ptr <= (o_idx == IW'(NUM_REQ - 1)) ? '0 : o_idx + 1'b1;
    end

endmodule

// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter: round-robin arbiter + APB master; APB_TIMEOUT_EN adds an ACCESS-phase timeout
module apb_master_arbiter
    import apb_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int DATA_WIDTH     = APB_DATA_WIDTH,
    parameter int ADDR_WIDTH     = APB_ADDR_WIDTH,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                          pclk,
    input  logic                          prst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            done,
    output logic [DATA_WIDTH-1:0]         rdata,
    output logic                          err,
    output logic                          psel,
    output logic                          penable,
    output logic                          pwrite,
    output logic [ADDR_WIDTH-1:0]         paddr,
    output logic [DATA_WIDTH-1:0]         pwdata,
    input  logic [DATA_WIDTH-1:0]         prdata,
    input  logic                          pready,
    output logic                          t_valid
);

    localparam int IW = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("apb_master_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
    end

    apb_master_state_e     r_state, w_next;
    logic [NUM_REQ-1:0]    r_gnt, r_done, w_arb_req, w_grant;
    logic [IW-1:0]         w_idx;
    logic                  r_psel, r_penable, r_pwrite;
    logic [ADDR_WIDTH-1:0] r_paddr;
    logic [DATA_WIDTH-1:0] r_pwdata, r_rdata;
    logic                  w_take, w_complete, w_timeout;

    // the owner is masked while it holds gnt and again in its done cycle,
    // so it cannot re-win before its req deassertion is visible
    assign w_arb_req = req & ~r_gnt & ~r_done;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .i_clk    (pclk),
        .i_rst    (prst),
        .i_req    (w_arb_req),
        .i_update (w_take),
        .o_grant  (w_grant),
        .o_idx    (w_idx)
    );

`ifdef APB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] r_cnt;
    logic          r_err;

    // counts stalled ACCESS cycles; zero whenever not in ACCESS
    always_ff @(posedge pclk) begin
        if (prst || r_state != ACCESS) r_cnt <= '0;
        else if (!pready) r_cnt <= r_cnt + 1'b1;
    end

    // err qualifies the done pulse of an aborted transfer
    always_ff @(posedge pclk) begin
        if (prst) r_err <= 1'b0;
        else r_err <= w_timeout;
    end

    assign err = r_err;
    assign w_timeout = (r_state == ACCESS) && !pready && (r_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
    assign err = 1'b0;
    assign w_timeout = 1'b0;
`endif

    // next state plus the grant/complete strobes that drive the registers
    always_comb begin
        w_next = r_state;
        w_take = 1'b0;
        w_complete = 1'b0;
        case (r_state)
            IDLE: begin
                w_take = |w_arb_req;
                w_next = w_take ? SETUP : IDLE;
            end
            SETUP: w_next = ACCESS;
            ACCESS: begin
                w_complete = pready;
                w_take = pready & |w_arb_req;
                w_next = w_take ? SETUP : (pready || w_timeout) ? IDLE : ACCESS;
            end
            default: w_next = IDLE;
        endcase
    end

    // state register and all registered APB / requester outputs
    always_ff @(posedge pclk) begin
        if (prst) begin
            r_state   <= IDLE;
            r_gnt     <= '0;
            r_done    <= '0;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_pwrite  <= 1'b0;
            r_paddr   <= '0;
            r_pwdata  <= '0;
            r_rdata   <= '0;
        end else begin
            r_state <= w_next;
            r_done  <= (w_complete || w_timeout) ? r_gnt : '0;
            if (w_complete && !r_pwrite) r_rdata <= prdata;
            if (w_take) begin
                r_gnt     <= w_grant;
                r_psel    <= 1'b1;
                r_penable <= 1'b0;
                r_pwrite  <= req_write[w_idx];
                r_paddr   <= req_addr[w_idx*ADDR_WIDTH +: ADDR_WIDTH];
                r_pwdata  <= req_wdata[w_idx*DATA_WIDTH +: DATA_WIDTH];
            end else if (w_next == ACCESS) begin
                r_penable <= 1'b1;
            end else if (w_next == IDLE) begin
                r_gnt     <= '0;
                r_psel    <= 1'b0;
                r_penable <= 1'b0;
            end
        end
    end

    assign gnt     = r_gnt;
    assign done    = r_done;
    assign rdata   = r_rdata;
    assign psel    = r_psel;
    assign penable = r_penable;
    assign pwrite  = r_pwrite;
    assign paddr   = r_paddr;
    assign pwdata  = r_pwdata;
    assign t_valid = r_psel & r_penable & |(req & ~r_gnt);

endmodule

// File: tb/tb_apb_master_arbiter.sv
// tb_apb_master_arbiter: directed stimulus with a done-driven scoreboard and a stub APB memory completer
module tb_apb_master_arbiter;

    localparam int N  = 2;
    localparam int DW = 16;
    localparam int AW = 4;

    logic            pclk = 1'b0;
    logic            prst;
    logic [N-1:0]    req, req_write, gnt, done;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [DW-1:0]   rdata, pwdata, prdata;
    logic [AW-1:0]   paddr;
    logic            err, psel, penable, pwrite, pready, t_valid;

    typedef struct {
        int          idx;
        bit          rd;
        logic [15:0] rdata;
        bit          err;
    } exp_t;

    exp_t        sbq[$];
    exp_t        mon_e;
    int          checks = 0;
    int          failures = 0;

    logic [15:0] mem [16];
    int          acc_cnt = 0;
    int          ws = 1;
    bit          stall = 1'b0;

    apb_master_arbiter #(
        .NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(16)
    ) dut (
        .pclk(pclk), .prst(prst), .req(req), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .done(done),
        .rdata(rdata), .err(err), .psel(psel), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
        .pready(pready), .t_valid(t_valid)
    );

    always #5 pclk = ~pclk;

    // stub completer: pready after ws stalled ACCESS cycles (team slave: ws=1)
    assign pready = psel & penable & (acc_cnt == ws) & !stall;
    assign prdata = mem[paddr];

    always @(posedge pclk) begin
        acc_cnt <= (psel && penable && !pready) ? acc_cnt + 1 : 0;
        if (psel && penable && pready && pwrite) mem[paddr] <= pwdata;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // scoreboard monitor: every done pulse must match the oldest expectation
    always @(negedge pclk) begin
        if (!prst && done != '0) begin
            if (sbq.size() == 0) begin
                chk("unexpected_done", 64'(done), 64'd0);
            end else begin
                mon_e = sbq.pop_front();
                chk("done_owner", 64'(done), 64'(1) << mon_e.idx);
                chk("done_err", 64'(err), 64'(mon_e.err));
                if (mon_e.rd) chk("done_rdata", 64'(rdata), 64'(mon_e.rdata));
            end
        end
    end

    task automatic cyc();
        @(negedge pclk);
    endtask

    task automatic issue(input int idx, input bit wr, input logic [3:0] a, input logic [15:0] wd,
                         input logic [15:0] exp_rd, input bit exp_err, input bit push);
        exp_t e;
        req_write[idx] = wr;
        req_addr[idx*AW +: AW] = a;
        req_wdata[idx*DW +: DW] = wd;
        req[idx] = 1'b1;
        e.idx = idx;
        e.rd = !wr;
        e.rdata = exp_rd;
        e.err = exp_err;
        if (push) sbq.push_back(e);
    endtask

    task automatic wait_done(input int idx);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            cyc();
            seen = done[idx];
        end
        if (!seen) chk("done_timeout", 64'd0, 64'd1);
        req[idx] = 1'b0;
    endtask

    initial begin
        int n;
        int bad;
        prst = 1'b1;
        req = '0;
        req_write = '0;
        req_addr = '0;
        req_wdata = '0;
        repeat (3) cyc();
        chk("reset_outputs", {gnt, done, psel, penable, pwrite, paddr, pwdata, rdata, err, t_valid}, 64'd0);
        prst = 1'b0;
        cyc();

        // contention from pointer 0: order 0 then 1, back-to-back SETUP
        issue(0, 1'b1, 4'h5, 16'h1111, 16'h0, 1'b0, 1'b1);
        issue(1, 1'b1, 4'h6, 16'h2222, 16'h0, 1'b0, 1'b1);
        cyc();
        chk("cont_c1_gnt", 64'(gnt), 64'h1);
        cyc();
        chk("cont_c2_tvalid", 64'(t_valid), 64'd1);
        cyc();
        chk("cont_c3_tvalid", 64'(t_valid), 64'd1);
        cyc();
        chk("cont_c4_setup2", {psel, penable, gnt, paddr}, {1'b1, 1'b0, 2'b10, 4'h6});
        req[0] = 1'b0;
        wait_done(1);
        repeat (2) cyc();

        // single write with cycle-exact timing
        issue(0, 1'b1, 4'h3, 16'hA5A5, 16'h0, 1'b0, 1'b1);
        cyc();
        chk("wr_c1_setup", {psel, penable, pwrite, gnt, paddr, pwdata}, {1'b1, 1'b0, 1'b1, 2'b01, 4'h3, 16'hA5A5});
        cyc();
        chk("wr_c2_access", {penable, paddr, t_valid}, {1'b1, 4'h3, 1'b0});
        cyc();
        chk("wr_c3_wait", {penable, paddr, done}, {1'b1, 4'h3, 2'b00});
        cyc();
        chk("wr_c4_done", {done, psel, gnt}, {2'b01, 1'b0, 2'b00});
        req[0] = 1'b0;
        repeat (2) cyc();

        // read back from requester 1, rdata holds after done
        issue(1, 1'b0, 4'h3, 16'h0, 16'hA5A5, 1'b0, 1'b1);
        wait_done(1);
        repeat (2) cyc();
        chk("rdata_hold", 64'(rdata), 64'hA5A5);

        // fairness: both held, alternate 0,1 over 8 transfers
        for (int i = 0; i < 8; i++) begin
            exp_t e;
            e.idx = i % 2;
            e.rd = 1'b0;
            e.rdata = 16'h0;
            e.err = 1'b0;
            sbq.push_back(e);
        end
        req_write = 2'b11;
        req_addr = {4'hB, 4'hA};
        req_wdata = {16'hBBBB, 16'hAAAA};
        req = 2'b11;
        n = 0;
        for (int i = 0; i < 200 && n < 8; i++) begin
            cyc();
            if (done != '0) begin
                n++;
                if (n >= 7) req = req & ~done;
            end
        end
        chk("fair_count", 64'(n), 64'd8);
        req = '0;
        repeat (3) cyc();

        // wait states: pready after 5 stalled cycles
        issue(0, 1'b1, 4'h9, 16'h1234, 16'h0, 1'b0, 1'b1);
        wait_done(0);
        cyc();
        ws = 5;
        issue(1, 1'b0, 4'h9, 16'h0, 16'h1234, 1'b0, 1'b1);
        repeat (2) cyc();
        bad = 0;
        for (int c = 2; c <= 7; c++) begin
            if (!(penable === 1'b1 && paddr === 4'h9 && done === 2'b00)) bad++;
            if (c < 7) cyc();
        end
        chk("ws_hold", 64'(bad), 64'd0);
        cyc();
        chk("ws_done_c8", 64'(done), 64'h2);
        req[1] = 1'b0;
        ws = 1;
        repeat (2) cyc();

        // reset during ACCESS aborts with no done
        issue(0, 1'b1, 4'h2, 16'hBEEF, 16'h0, 1'b0, 1'b0);
        repeat (2) cyc();
        chk("rst_in_access", 64'(penable), 64'd1);
        prst = 1'b1;
        cyc();
        chk("rst_outputs", {gnt, done, psel, penable, pwrite, paddr, pwdata, rdata, err, t_valid}, 64'd0);
        req = '0;
        prst = 1'b0;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            if (done !== 2'b00 || psel !== 1'b0) bad++;
        end
        chk("rst_no_done", 64'(bad), 64'd0);

`ifdef APB_TIMEOUT_EN
        // timeout: abort after 16 stalled ACCESS cycles, then serve req[1]
        stall = 1'b1;
        issue(0, 1'b0, 4'h3, 16'h0, 16'h0, 1'b1, 1'b1);
        issue(1, 1'b1, 4'h4, 16'h4444, 16'h0, 1'b0, 1'b1);
        repeat (17) cyc();
        chk("to_c17_wait", {penable, done}, {1'b1, 2'b00});
        cyc();
        chk("to_c18_abort", {done, err, psel, penable}, {2'b01, 1'b1, 1'b0, 1'b0});
        stall = 1'b0;
        req[0] = 1'b0;
        wait_done(1);
        repeat (2) cyc();
`endif

        chk("sb_empty", 64'(sbq.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
